writeback_queue: RTL and testbench



---
 rtl/writeback_queue.sv | 138 +++++++++++++
 tb/tb_writeback_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: FIFO of register write-back requests between execute and the
// register-file write-port demux. Issues one write per cycle, absorbs write-port
// stalls and offers a combinational probe so decode can see pending writes.
//
// Optional feature macro: WRITEBACK_QUEUE_FORWARD_EN
//   defined     -> probe_data returns the youngest pending value for probe_index
//   not defined -> probe_data tied to '0; probe_hit still reports pending writes
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    execute-side handshake; in_ready = (count != DEPTH)
//   in_data, in_index    write-back word and destination register
//   drain_stall          write port busy, hold off the pop this cycle
//   out_valid            one-cycle write strobe to the register file
//   out_data, out_index  demux data_in / index (held while out_valid is 0)
//   probe_index          register queried by decode
//   probe_hit/probe_data pending-write match and youngest value (combinational)
//   count                occupied entries
module writeback_queue #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned SELECT_WIDTH = 4,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [SELECT_WIDTH-1:0]    in_index,
    input  logic                       drain_stall,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [SELECT_WIDTH-1:0]    out_index,
    input  logic [SELECT_WIDTH-1:0]    probe_index,
    output logic                       probe_hit,
    output logic [WIDTH-1:0]           probe_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0]        r_mem_data  [DEPTH];
    logic [SELECT_WIDTH-1:0] r_mem_index [DEPTH];

    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;
    logic                    r_out_valid;
    logic [WIDTH-1:0]        r_out_data;
    logic [SELECT_WIDTH-1:0] r_out_index;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_probe_hit;

    // in_ready looks only at the registered count, never at this cycle's pop
    assign in_ready = (r_count != CNT_W'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && !drain_stall;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign count     = r_count;
    assign probe_hit = w_probe_hit;

    // Entry storage: not reset, validity is carried by count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_tail]  <= in_data;
            r_mem_index[r_tail] <= in_index;
        end
    end

    // Pointers, occupancy and the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
        end else begin
            r_out_valid <= w_pop;
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head      <= r_head + PTR_W'(1);
                r_out_data  <= r_mem_data[r_head];
                r_out_index <= r_mem_index[r_head];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WRITEBACK_QUEUE_FORWARD_EN
    logic [WIDTH-1:0] w_probe_data;
    assign probe_data = w_probe_data;

    // Walk oldest to youngest after the output register, so the youngest match wins
    always_comb begin
        w_probe_hit  = 1'b0;
        w_probe_data = '0;
        if (r_out_valid && (r_out_index == probe_index)) begin
            w_probe_hit  = 1'b1;
            w_probe_data = r_out_data;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_mem_index[r_head + PTR_W'(i)] == probe_index)) begin
                w_probe_hit  = 1'b1;
                w_probe_data = r_mem_data[r_head + PTR_W'(i)];
            end
        end
    end
`else
    assign probe_data = '0;

    // Hit detection only; decode stalls on a hit
    always_comb begin
        w_probe_hit = r_out_valid && (r_out_index == probe_index);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_mem_index[r_head + PTR_W'(i)] == probe_index)) begin
                w_probe_hit = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (WIDTH=16, SELECT_WIDTH=4, DEPTH=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_writeback_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_index;
    logic        drain_stall;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  out_index;
    logic [3:0]  probe_index;
    logic        probe_hit;
    logic [15:0] probe_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_queue #(.WIDTH(16), .SELECT_WIDTH(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_index    (in_index),
        .drain_stall (drain_stall),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_index   (out_index),
        .probe_index (probe_index),
        .probe_hit   (probe_hit),
        .probe_data  (probe_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected probe_data for a matching value in the current build
    function automatic logic [15:0] fwd(input logic [15:0] v);
`ifdef WRITEBACK_QUEUE_FORWARD_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] idx);
        in_valid = v;
        in_data  = d;
        in_index = idx;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_index = '0;
        drain_stall = 1'b0; probe_index = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();

        // Latency and order
        drive(1'b1, 16'h1111, 4'd3); step();
        chk("lat_valid0", 32'(out_valid), 32'd0);
        chk("lat_count1", 32'(count), 32'd1);
        drive(1'b1, 16'h2222, 4'd5); step();
        chk("lat_valid1", 32'(out_valid), 32'd1);
        chk("lat_data1", 32'(out_data), 32'h1111);
        chk("lat_idx1", 32'(out_index), 32'd3);
        drive(1'b1, 16'h3333, 4'd3); step();
        chk("lat_valid2", 32'(out_valid), 32'd1);
        chk("lat_data2", 32'(out_data), 32'h2222);
        chk("lat_idx2", 32'(out_index), 32'd5);
        chk("lat_count2", 32'(count), 32'd1);
        drive(1'b0, 16'h0, 4'd0); step();
        chk("lat_valid3", 32'(out_valid), 32'd1);
        chk("lat_data3", 32'(out_data), 32'h3333);
        chk("lat_idx3", 32'(out_index), 32'd3);
        chk("lat_count3", 32'(count), 32'd0);
        step();
        chk("lat_valid4", 32'(out_valid), 32'd0);
        chk("lat_hold", 32'(out_data), 32'h3333);

        // Full and stall
        drain_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'h5000 + 16'(k), 4'(k)); step();
            chk("full_count", 32'(count), 32'(k + 1));
            chk("full_nopop", 32'(out_valid), 32'd0);
        end
        drive(1'b1, 16'h5004, 4'd4);
        chk("full_ready0", 32'(in_ready), 32'd0);
        step();
        chk("full_held", 32'(count), 32'd4);
        drain_stall = 1'b0; step();
        chk("full_pop0", 32'(out_data), 32'h5000);
        chk("full_refused", 32'(count), 32'd3);
        chk("full_ready1", 32'(in_ready), 32'd1);
        step();
        chk("full_pop1", 32'(out_data), 32'h5001);
        chk("full_accept", 32'(count), 32'd3);
        drive(1'b0, 16'h0, 4'd0);
        for (int k = 2; k < 5; k++) begin
            step();
            chk("full_drain_v", 32'(out_valid), 32'd1);
            chk("full_drain_d", 32'(out_data), 32'h5000 + 32'(k));
            chk("full_drain_c", 32'(count), 32'(4 - k));
        end
        step();
        chk("full_idle", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at count=2 with pointer wrap
        drain_stall = 1'b1;
        drive(1'b1, 16'h6000, 4'd0); step();
        drive(1'b1, 16'h6001, 4'd1); step();
        chk("sim_count_init", 32'(count), 32'd2);
        drain_stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'h6002 + 16'(k), 4'(k + 2)); step();
            chk("sim_data", 32'(out_data), 32'h6000 + 32'(k));
            chk("sim_count", 32'(count), 32'd2);
        end
        drive(1'b0, 16'h0, 4'd0); step();
        chk("sim_tail0", 32'(out_data), 32'h600A);
        step();
        chk("sim_tail1", 32'(out_data), 32'h600B);
        chk("sim_empty", 32'(count), 32'd0);
        step();

        // Probe priority
        drain_stall = 1'b1;
        drive(1'b1, 16'hAAAA, 4'd7); step();
        drive(1'b1, 16'hBBBB, 4'd7); step();
        drive(1'b0, 16'h0, 4'd0);
        probe_index = 4'd7; #1;
        chk("prb_hit7", 32'(probe_hit), 32'd1);
        chk("prb_data7", 32'(probe_data), 32'(fwd(16'hBBBB)));
        probe_index = 4'd2; #1;
        chk("prb_hit2", 32'(probe_hit), 32'd0);
        chk("prb_data2", 32'(probe_data), 32'd0);
        probe_index = 4'd7;
        drain_stall = 1'b0; step();
        chk("prb_outreg_lose", 32'(probe_data), 32'(fwd(16'hBBBB)));
        chk("prb_outreg_hit", 32'(probe_hit), 32'd1);
        step();
        chk("prb_last_hit", 32'(probe_hit), 32'd1);
        chk("prb_last_data", 32'(probe_data), 32'(fwd(16'hBBBB)));
        step();
        chk("prb_gone", 32'(probe_hit), 32'd0);

        // Probe of the output register
        probe_index = 4'd9;
        drive(1'b1, 16'h9999, 4'd9); step();
        drive(1'b0, 16'h0, 4'd0);
        chk("r9_queued_hit", 32'(probe_hit), 32'd1);
        chk("r9_queued_data", 32'(probe_data), 32'(fwd(16'h9999)));
        step();
        chk("r9_out_valid", 32'(out_valid), 32'd1);
        chk("r9_out_hit", 32'(probe_hit), 32'd1);
        chk("r9_out_data", 32'(probe_data), 32'(fwd(16'h9999)));
        step();
        chk("r9_miss", 32'(probe_hit), 32'd0);
        chk("r9_miss_data", 32'(probe_data), 32'd0);

        // Reset mid-drain
        drain_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'hC000 + 16'(k), 4'(k + 10)); step();
        end
        drive(1'b0, 16'h0, 4'd0);
        drain_stall = 1'b0; step();
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_count", 32'(count), 32'd2);
        rst_n = 1'b0; #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_idx", 32'(out_index), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_count", 32'(count), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
